// File: rtl/inert_spi_resp_if.sv
// ============================================================================
// Module   : inert_spi_resp_if
// Brief    : Four-wire SPI bundle between the inertial master and responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inert_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

`default_nettype wire

// File: rtl/inert_spi_resp.sv
// ============================================================================
// Module   : inert_spi_resp
// Brief    : SPI mode-0 responder emulating the inertial sensor register map.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inert_spi_resp #(
    parameter int          ODR_CYCLES   = 50000,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    inert_spi_resp_if.slave   spi,
    output logic              INT,
    input  wire logic [47:0]  gyro,
    input  wire logic [47:0]  accel
);

    localparam int                CNT_W   = (ODR_CYCLES > 1) ? $clog2(ODR_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ODR_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        ss_sync_q, ss_sync_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              first_fall_q, first_fall_d;
    logic              miso_q, miso_d;
    logic [7:0]        int1_ctrl_q, int1_ctrl_d;
    logic [7:0]        ctrl1_xl_q, ctrl1_xl_d;
    logic [7:0]        ctrl2_g_q, ctrl2_g_d;
    logic [CNT_W-1:0]  odr_cnt_q, odr_cnt_d;
    logic              pend_q, pend_d;
    logic              latch_pulse_q, latch_pulse_d;
    logic [47:0]       gyro_reg_q, gyro_reg_d;
    logic [47:0]       accel_reg_q, accel_reg_d;
    logic              int_q, int_d;

    logic       ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [7:0] cmd_byte, rd_data;
    logic       commit, wr_en, rd_done, odr_run, tick, do_latch;

    assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign cmd_byte  = {shift_q[6:0], mosi_sync_q[1]};

    assign commit   = ss_rise && (state_q == S_DATA) && (bit_cnt_q == 5'd16);
    assign wr_en    = commit && !rw_q;
    assign rd_done  = commit && rw_q;
    assign odr_run  = (ctrl2_g_q[7:4] != 4'd0);
    assign tick     = odr_run && (odr_cnt_q == CNT_MAX);
    assign do_latch = (tick || pend_q) && (state_q == S_IDLE);

    always_comb begin
        rd_data = 8'h00;
        case (cmd_byte[6:0])
            7'h0D:   rd_data = int1_ctrl_q;
            7'h0F:   rd_data = WHO_AM_I_VAL;
            7'h10:   rd_data = ctrl1_xl_q;
            7'h11:   rd_data = ctrl2_g_q;
            7'h22:   rd_data = gyro_reg_q[7:0];
            7'h23:   rd_data = gyro_reg_q[15:8];
            7'h24:   rd_data = gyro_reg_q[23:16];
            7'h25:   rd_data = gyro_reg_q[31:24];
            7'h26:   rd_data = gyro_reg_q[39:32];
            7'h27:   rd_data = gyro_reg_q[47:40];
            7'h28:   rd_data = accel_reg_q[7:0];
            7'h29:   rd_data = accel_reg_q[15:8];
            7'h2A:   rd_data = accel_reg_q[23:16];
            7'h2B:   rd_data = accel_reg_q[31:24];
            7'h2C:   rd_data = accel_reg_q[39:32];
            7'h2D:   rd_data = accel_reg_q[47:40];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (ss_fall) state_d = S_CMD;
                S_CMD:   if (sclk_rise && bit_cnt_q == 5'd7) state_d = S_DATA;
                S_DATA:  state_d = S_DATA;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ss_sync_d     = {ss_sync_q[1:0], spi.SS_n};
        sclk_sync_d   = {sclk_sync_q[1:0], spi.SCLK};
        mosi_sync_d   = {mosi_sync_q[0], spi.MOSI};
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        tx_d          = tx_q;
        first_fall_d  = first_fall_q;
        miso_d        = miso_q;
        int1_ctrl_d   = int1_ctrl_q;
        ctrl1_xl_d    = ctrl1_xl_q;
        ctrl2_g_d     = ctrl2_g_q;
        int_d         = int_q;

        case (state_q)
            S_IDLE: if (ss_fall) begin
                bit_cnt_d    = 5'd0;
                shift_d      = 8'h00;
                first_fall_d = 1'b1;
            end
            S_CMD: if (sclk_rise) begin
                shift_d   = cmd_byte;
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7) begin
                    rw_d   = cmd_byte[7];
                    addr_d = cmd_byte[6:0];
                    tx_d   = cmd_byte[7] ? rd_data : 8'h00;
                end
            end
            S_DATA: begin
                if (sclk_rise) begin
                    shift_d = cmd_byte;
                    // Saturate so an over-long frame can never wrap back to 16.
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall && rw_q) begin
                    if (first_fall_q) begin
                        miso_d       = tx_q[7];
                        first_fall_d = 1'b0;
                    end else begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        miso_d = tx_q[6];
                    end
                end
            end
            default: ;
        endcase
        if (ss_rise || state_q != S_DATA) miso_d = 1'b1;

        if (wr_en) begin
            case (addr_q)
                7'h0D:   int1_ctrl_d = shift_q;
                7'h10:   ctrl1_xl_d  = shift_q;
                7'h11:   ctrl2_g_d   = shift_q;
                default: ;
            endcase
        end

        if (!odr_run || tick) odr_cnt_d = '0;
        else                  odr_cnt_d = odr_cnt_q + CNT_W'(1);
        if (wr_en && addr_q == 7'h11 && shift_q[7:4] == 4'd0) odr_cnt_d = '0;

        // A tick during a frame is parked until IDLE so multi-byte reads never tear.
        pend_d = pend_q;
        if (do_latch)  pend_d = 1'b0;
        else if (tick) pend_d = 1'b1;
        latch_pulse_d = do_latch;
        gyro_reg_d    = do_latch ? gyro  : gyro_reg_q;
        accel_reg_d   = do_latch ? accel : accel_reg_q;

        if (rd_done && addr_q >= 7'h22 && addr_q <= 7'h27) int_d = 1'b0;
        if (wr_en && addr_q == 7'h0D && !shift_q[1])       int_d = 1'b0;
        if (latch_pulse_q && int1_ctrl_q[1])               int_d = 1'b1;
    end

    // Sync chains reset low so a release with SS_n held low does not look like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q     <= 3'b000;
            sclk_sync_q   <= 3'b000;
            mosi_sync_q   <= 2'b00;
            bit_cnt_q     <= 5'd0;
            shift_q       <= 8'h00;
            rw_q          <= 1'b0;
            addr_q        <= 7'h00;
            tx_q          <= 8'h00;
            first_fall_q  <= 1'b0;
            miso_q        <= 1'b1;
            int1_ctrl_q   <= 8'h00;
            ctrl1_xl_q    <= 8'h00;
            ctrl2_g_q     <= 8'h00;
            odr_cnt_q     <= '0;
            pend_q        <= 1'b0;
            latch_pulse_q <= 1'b0;
            gyro_reg_q    <= 48'h0;
            accel_reg_q   <= 48'h0;
            int_q         <= 1'b0;
        end else begin
            ss_sync_q     <= ss_sync_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            tx_q          <= tx_d;
            first_fall_q  <= first_fall_d;
            miso_q        <= miso_d;
            int1_ctrl_q   <= int1_ctrl_d;
            ctrl1_xl_q    <= ctrl1_xl_d;
            ctrl2_g_q     <= ctrl2_g_d;
            odr_cnt_q     <= odr_cnt_d;
            pend_q        <= pend_d;
            latch_pulse_q <= latch_pulse_d;
            gyro_reg_q    <= gyro_reg_d;
            accel_reg_q   <= accel_reg_d;
            int_q         <= int_d;
        end
    end

    assign spi.MISO = miso_q;
    assign INT      = int_q;

endmodule

`default_nettype wire

// File: tb/tb_inert_spi_resp.sv
// ============================================================================
// Module   : tb_inert_spi_resp
// Brief    : Directed self-checking bench for inert_spi_resp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inert_spi_resp;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic [47:0] gyro;
    logic [47:0] accel;
    int          errors;
    int          checks;

    inert_spi_resp_if spi ();

    inert_spi_resp #(
        .ODR_CYCLES   (64),
        .WHO_AM_I_VAL (8'h6A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (spi),
        .INT   (INT),
        .gyro  (gyro),
        .accel (accel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SCLK half period is 8 clk; MISO is sampled as the master raises SCLK.
    task automatic spi_xfer(input logic [15:0] word, input int nrise,
                            output logic [7:0] rdata, output logic miso_idle);
        rdata = 8'h00;
        spi.SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            spi.MOSI = word[15-i];
            repeat (8) @(negedge clk);
            spi.SCLK = 1'b1;
            if (i >= 8) rdata = {rdata[6:0], spi.MISO};
            repeat (8) @(negedge clk);
            spi.SCLK = 1'b0;
        end
        repeat (8) @(negedge clk);
        spi.SS_n = 1'b1;
        repeat (3) @(negedge clk);
        miso_idle = spi.MISO;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        spi.SS_n = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
        gyro = 48'h0; accel = 48'h0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (spi.MISO !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", spi.MISO); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", INT); end
    endtask

    task automatic test_who_am_i;
        logic [7:0] rd; logic mi;
        spi_xfer(16'h8F00, 16, rd, mi);
        checks++; if (rd !== 8'h6A) begin errors++; $display("FAIL who_am_i: got %h expected 6a", rd); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL who_int: got %b expected 0", INT); end
        checks++; if (mi !== 1'b1) begin errors++; $display("FAIL who_miso_idle: got %b expected 1", mi); end
    endtask

    task automatic test_write_readback;
        logic [7:0] rd; logic mi;
        spi_xfer(16'h1180, 16, rd, mi);
        spi_xfer(16'h9100, 16, rd, mi);
        checks++; if (rd !== 8'h80) begin errors++; $display("FAIL ctrl2_g_rb: got %h expected 80", rd); end
        repeat (200) @(negedge clk);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_gated: got %b expected 0", INT); end
        spi_xfer(16'h8500, 16, rd, mi);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmapped: got %h expected 00", rd); end
        spi_xfer(16'h0F55, 16, rd, mi);
        spi_xfer(16'h8F00, 16, rd, mi);
        checks++; if (rd !== 8'h6A) begin errors++; $display("FAIL who_ro: got %h expected 6a", rd); end
        spi_xfer(16'h10A5, 16, rd, mi);
        spi_xfer(16'h9000, 16, rd, mi);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL ctrl1_xl_rb: got %h expected a5", rd); end
        checks++; if (mi !== 1'b1) begin errors++; $display("FAIL rb_miso_idle: got %b expected 1", mi); end
    endtask

    task automatic test_data_ready;
        logic [7:0] rd; logic mi; bit seen;
        gyro  = {16'h0003, 16'h0002, 16'h1234};
        accel = {16'h0000, 16'h0000, 16'hBEEF};
        spi_xfer(16'h0D02, 16, rd, mi);
        spi_xfer(16'h1180, 16, rd, mi);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (INT === 1'b1) seen = 1'b1;
        end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL int_set: got %b expected 1", INT); end
        spi_xfer(16'h1100, 16, rd, mi);
        spi_xfer(16'hA200, 16, rd, mi);
        checks++; if (rd !== 8'h34) begin errors++; $display("FAIL gyro_xl: got %h expected 34", rd); end
        spi_xfer(16'hA300, 16, rd, mi);
        checks++; if (rd !== 8'h12) begin errors++; $display("FAIL gyro_xh: got %h expected 12", rd); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL int_clear: got %b expected 0", INT); end
        spi_xfer(16'hA400, 16, rd, mi);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL gyro_yl: got %h expected 02", rd); end
        spi_xfer(16'hA800, 16, rd, mi);
        checks++; if (rd !== 8'hEF) begin errors++; $display("FAIL accel_xl: got %h expected ef", rd); end
    endtask

    task automatic test_deferred_latch;
        logic [7:0] rd; logic mi;
        spi_xfer(16'h1180, 16, rd, mi);
        fork
            spi_xfer(16'hA300, 16, rd, mi);
            begin
                repeat (30) @(negedge clk);
                gyro = {16'h0003, 16'h0002, 16'h5678};
            end
        join
        checks++; if (rd !== 8'h12) begin errors++; $display("FAIL deferred_old: got %h expected 12", rd); end
        spi_xfer(16'hA300, 16, rd, mi);
        checks++; if (rd !== 8'h56) begin errors++; $display("FAIL deferred_new: got %h expected 56", rd); end
        spi_xfer(16'h1100, 16, rd, mi);
    endtask

    task automatic test_abort;
        logic [7:0] rd; logic mi;
        spi_xfer(16'h0DFF, 12, rd, mi);
        checks++; if (mi !== 1'b1) begin errors++; $display("FAIL abort_miso_idle: got %b expected 1", mi); end
        spi_xfer(16'h8D00, 16, rd, mi);
        checks++; if (rd !== 8'h02) begin errors++; $display("FAIL abort_int1: got %h expected 02", rd); end
        spi_xfer(16'h8F00, 16, rd, mi);
        checks++; if (rd !== 8'h6A) begin errors++; $display("FAIL abort_next: got %h expected 6a", rd); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] rd; logic mi; bit seen;
        spi_xfer(16'h1180, 16, rd, mi);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (INT === 1'b1) seen = 1'b1;
        end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL pre_reset_int: got %b expected 1", INT); end
        fork
            spi_xfer(16'h8F00, 16, rd, mi);
            begin
                repeat (145) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                checks++; if (spi.MISO !== 1'b1) begin errors++; $display("FAIL rst_miso: got %b expected 1", spi.MISO); end
                checks++; if (INT !== 1'b0) begin errors++; $display("FAIL rst_int: got %b expected 0", INT); end
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        spi_xfer(16'h9100, 16, rd, mi);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_ctrl2_g: got %h expected 00", rd); end
        spi_xfer(16'h8D00, 16, rd, mi);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_int1: got %h expected 00", rd); end
        spi_xfer(16'h8F00, 16, rd, mi);
        checks++; if (rd !== 8'h6A) begin errors++; $display("FAIL rst_who: got %h expected 6a", rd); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_who_am_i();
        test_write_readback();
        test_data_ready();
        test_deferred_latch();
        test_abort();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inert_spi_resp.md
Name: inert_spi_resp

Overview:
- Synthesizable SPI responder that emulates the inertial sensor at the far end of the inertial interface's SPI link.
- Decodes 16-bit read/write frames from the SPI master and serves a small register map: config registers, WHO_AM_I, and gyro/accel data registers.
- Raises INT when a new sample is latched.
- Used on the FPGA and in benches as the slave that the inertial interface talks to.

Parameters:
ODR_CYCLES, 50000, clk cycles between sample ticks (output data rate)
WHO_AM_I_VAL, 8'h6A, value returned at address 0x0F

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  SPI slave select from master, active low
SCLK  input  1  SPI clock from master, idle low (mode 0)
MOSI  input  1  SPI data from master, MSB first
MISO  output  1  SPI data to master
INT  output  1  data-ready interrupt, active high
gyro  input  48  live gyro sample {z,y,x}, 16 bits each
accel  input  48  live accel sample {z,y,x}, 16 bits each

Behaviour:
- Reset: MISO=1, INT=0, all registers 0 except WHO_AM_I, state IDLE, ODR counter 0.
- SS_n, SCLK and MOSI are each double-flopped into clk. Edges are detected on the synchronized signals. clk must be at least 8x SCLK.
- Frame format: 16 bits, MSB first. Bit15 = R/W (1 = read). Bits14:8 = address. Bits7:0 = write data (ignored on a read).
- MOSI is sampled on synced SCLK rise. MISO changes on synced SCLK fall.
- States:
  - IDLE: SS_n fall -> CMD, bit count cleared.
  - CMD: shift MOSI on each rise. At the 8th rise, latch the command byte; if read, load an 8-bit tx register from reg[addr]; go to DATA.
  - DATA: on the first fall in DATA, MISO = tx[7]. Each later fall shifts left. Rises keep shifting MOSI into the rx byte.
  - SS_n rise from any state -> IDLE.
- Commit rule:
  - A write commits only if SS_n rises after exactly 16 rises.
  - A read counts as completed under the same condition.
  - SS_n rise with any other count (including mid-CMD) aborts: no write, no completion side effects.
- MISO is 1 whenever not in DATA of a read frame. It returns to 1 within 3 clk of SS_n rise.
- Register map:
  - 0x0D INT1_CTRL, rw.
  - 0x0F WHO_AM_I, ro.
  - 0x10 CTRL1_XL, rw.
  - 0x11 CTRL2_G, rw.
  - 0x22-0x27 gyro x,y,z as L,H bytes, ro.
  - 0x28-0x2D accel x,y,z as L,H bytes, ro.
  - Any other address reads 0x00; writes to it are ignored. Writes to ro addresses are ignored.
- ODR counter runs only while CTRL2_G[7:4] != 0. It counts 0..ODR_CYCLES-1 and produces a 1-cycle tick at wrap. Writing CTRL2_G[7:4]=0 clears the counter.
- On a tick, gyro and accel are latched into the data registers. The latch is atomic across all 96 bits.
- If the tick occurs while state != IDLE, the latch is deferred to the first cycle after return to IDLE. Only one pending tick is kept; further ticks are dropped. This prevents torn multi-byte reads.
- INT:
  - Set the cycle after a data latch if INT1_CTRL[1]=1.
  - Cleared when a read of 0x22-0x27 completes.
  - If set and clear fall in the same cycle, set wins.
  - Writing INT1_CTRL[1]=0 clears INT.
- Reset asserted mid-frame: everything returns to reset values immediately. The next frame after rst_n release starts clean on the next SS_n fall.

Test Plan:
1. Read WHO_AM_I: master frame 16'h8F00 -> MISO shifts 8'h6A in bits 7:0; INT stays 0.
2. Write/readback: 16'h1180 then 16'h9100 -> second frame returns 8'h80; ODR ticks begin every ODR_CYCLES (use 64 in bench).
3. Data ready: INT1_CTRL=8'h02, CTRL2_G=8'h80, gyro={16'h0003,16'h0002,16'h1234}. After a tick, INT=1. Read 0x22 -> 8'h34; read 0x23 -> 8'h12; INT clears after the 0x23 read completes.
4. Deferred latch: hold SS_n low across a tick while reading 0x23, with gyro changed to 16'h5678 mid-frame. The frame returns the old high byte 8'h12. The next read of 0x23 -> 8'h56.
5. Abort: SS_n rises after 12 SCLK of write 16'h0DFF -> INT1_CTRL still 8'h02. Next frame decodes normally.
6. Reset mid-frame: assert rst_n low during DATA of a read -> MISO=1, INT=0, CTRL2_G=0. Subsequent 16'h8F00 returns 8'h6A.
